// File: rtl/mem_pkg.sv
// mem_pkg: load/store encodings, owner tag, stage-M payload and alignment check shared by mem_arb.
package mem_pkg;
   localparam logic [2:0] RD_NONE = 3'b000, RD_LB = 3'b001, RD_LBU = 3'b010, RD_LH = 3'b011, RD_LHU = 3'b100, RD_LW = 3'b101;
   localparam logic [1:0] WR_NONE = 2'b00, WR_B = 2'b01, WR_H = 2'b10, WR_W = 2'b11;
   localparam int AGE_W = 4;
   typedef enum logic {OWN_I, OWN_D} owner_e;
   typedef struct packed {
      logic       vld;
      owner_e     own;
      logic       err;
      logic [2:0] rd;
      logic [1:0] wr;
      logic [31:0] din;
   } stage_t;
   function automatic logic misaligned(input logic [2:0] rd, input logic [1:0] wr, input logic [1:0] a);
      return ((rd == RD_LW || wr == WR_W) && a != 2'b00) || ((rd == RD_LH || rd == RD_LHU || wr == WR_H) && a[0]);
   endfunction
endpackage

// File: rtl/mem_arb_age_cnt.sv
// arb_age_cnt: saturating count of cycles the fetch side has lost; flip hands priority to fetch.
module arb_age_cnt
   import mem_pkg::*;
#(
   parameter int MAX = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic inc,
   input  logic clr,
   output logic flip
);
   logic [AGE_W-1:0] cnt_q, cnt_d;
   always_comb cnt_d = clr ? '0 : (inc && cnt_q != AGE_W'(MAX)) ? cnt_q + 1'b1 : cnt_q;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else cnt_q <= cnt_d;
   end
   assign flip = cnt_q >= AGE_W'(MAX);
endmodule

// File: rtl/mem_arb.sv
// mem_arb: two-requester (fetch/data) arbiter and 2-stage sequencer for a single memory port.
// Optional MEM_ARB_PERF_EN adds stall and access counters.
module mem_arb
   import mem_pkg::*;
#(
   parameter int STARVE_MAX = 4,
   parameter int AW         = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_req,
   input  logic [AW-1:0] i_addr,
   output logic          i_gnt,
   output logic          i_rvalid,
   output logic [31:0]   i_rdata,
   input  logic          d_req,
   input  logic [AW-1:0] d_addr,
   input  logic [2:0]    d_rd_ctrl,
   input  logic [1:0]    d_wr_ctrl,
   input  logic [31:0]   d_wdata,
   output logic          d_gnt,
   output logic          d_rvalid,
   output logic [31:0]   d_rdata,
   output logic          d_err,
   output logic [AW-1:0] m_addr,
   output logic [2:0]    m_rd_ctrl,
   output logic [1:0]    m_wr_ctrl,
   output logic [31:0]   m_din,
   input  logic [31:0]   m_dout
`ifdef MEM_ARB_PERF_EN
  ,output logic [31:0]   perf_i_stall,
   output logic [31:0]   perf_d_stall,
   output logic [31:0]   perf_acc
`endif
);
   stage_t        st_q, st_d;
   logic [AW-1:0] addr_q, addr_d;
   logic          i_rvalid_q, i_rvalid_d, d_rvalid_q, d_rvalid_d, d_err_q, d_err_d;
   logic [31:0]   i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d, rdata;
   logic          starve, mis;

   arb_age_cnt #(.MAX(STARVE_MAX)) u_age (
      .clk  (clk),
      .rst  (rst),
      .inc  (i_req & ~i_gnt),
      .clr  (~i_req | i_gnt),
      .flip (starve)
   );

   assign d_gnt = d_req & (~starve | ~i_req);
   assign i_gnt = i_req & ~d_gnt;

   always_comb begin
      mis = misaligned(d_rd_ctrl, d_wr_ctrl, d_addr[1:0]);
      st_d = '0;
      addr_d = addr_q;
      if (i_gnt) begin
         st_d.vld = 1'b1;
         st_d.own = OWN_I;
         st_d.rd = RD_LW;
         addr_d = i_addr;
      end else if (d_gnt) begin
         st_d.vld = 1'b1;
         st_d.own = OWN_D;
         st_d.err = mis;
         st_d.rd = mis ? RD_NONE : d_rd_ctrl;
         st_d.wr = mis ? WR_NONE : d_wr_ctrl;
         st_d.din = (mis || d_wr_ctrl == WR_NONE) ? '0 : d_wdata;
         addr_d = d_addr;
      end
      // Read data is sampled before the write commits, so a read-modify access returns the old word.
      rdata = st_q.rd != RD_NONE ? m_dout : '0;
      i_rvalid_d = st_q.vld && st_q.own == OWN_I;
      d_rvalid_d = st_q.vld && st_q.own == OWN_D;
      i_rdata_d = i_rvalid_d ? rdata : '0;
      d_rdata_d = d_rvalid_d ? rdata : '0;
      d_err_d = d_rvalid_d && st_q.err;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st_q <= '0;
         addr_q <= '0;
         i_rvalid_q <= 1'b0;
         d_rvalid_q <= 1'b0;
         i_rdata_q <= '0;
         d_rdata_q <= '0;
         d_err_q <= 1'b0;
      end else begin
         st_q <= st_d;
         addr_q <= addr_d;
         i_rvalid_q <= i_rvalid_d;
         d_rvalid_q <= d_rvalid_d;
         i_rdata_q <= i_rdata_d;
         d_rdata_q <= d_rdata_d;
         d_err_q <= d_err_d;
      end
   end

   assign m_addr = addr_q;
   assign m_rd_ctrl = st_q.rd;
   assign m_wr_ctrl = st_q.wr;
   assign m_din = st_q.din;
   assign i_rvalid = i_rvalid_q;
   assign i_rdata = i_rdata_q;
   assign d_rvalid = d_rvalid_q;
   assign d_rdata = d_rdata_q;
   assign d_err = d_err_q;

`ifdef MEM_ARB_PERF_EN
   logic [31:0] i_stall_q, i_stall_d, d_stall_q, d_stall_d, acc_q, acc_d;
   always_comb begin
      i_stall_d = i_stall_q + 32'(i_req & ~i_gnt);
      d_stall_d = d_stall_q + 32'(d_req & ~d_gnt);
      acc_d = acc_q + 32'(i_gnt | d_gnt);
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         i_stall_q <= '0;
         d_stall_q <= '0;
         acc_q <= '0;
      end else begin
         i_stall_q <= i_stall_d;
         d_stall_q <= d_stall_d;
         acc_q <= acc_d;
      end
   end
   assign perf_i_stall = i_stall_q;
   assign perf_d_stall = d_stall_q;
   assign perf_acc = acc_q;
`endif
endmodule

// File: tb/tb_mem_arb.sv
// tb_mem_arb: scoreboard bench for mem_arb with a byte-lane memory model on the m_* port.
module tb_mem_arb;
   import mem_pkg::*;

   typedef struct {
      logic        own_d;
      logic [31:0] data;
      logic        err;
      int          cyc;
   } exp_t;

   logic        clk, rst;
   logic        i_req, i_gnt, i_rvalid;
   logic [31:0] i_addr, i_rdata;
   logic        d_req, d_gnt, d_rvalid, d_err;
   logic [31:0] d_addr, d_wdata, d_rdata;
   logic [2:0]  d_rd_ctrl, m_rd_ctrl;
   logic [1:0]  d_wr_ctrl, m_wr_ctrl;
   logic [31:0] m_addr, m_din, m_dout;
`ifdef MEM_ARB_PERF_EN
   logic [31:0] perf_i_stall, perf_d_stall, perf_acc;
`endif

   logic [31:0] mem [0:63];
   logic [31:0] wmask, rw;
   logic [7:0]  rb;
   logic [15:0] rh;
   exp_t        sb[$];
   int          compared = 0;
   int          mismatched = 0;
   int          cyc = 0;

   mem_arb #(.STARVE_MAX(4), .AW(32)) dut (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
      .d_req(d_req), .d_addr(d_addr), .d_rd_ctrl(d_rd_ctrl), .d_wr_ctrl(d_wr_ctrl), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
      .m_addr(m_addr), .m_rd_ctrl(m_rd_ctrl), .m_wr_ctrl(m_wr_ctrl), .m_din(m_din), .m_dout(m_dout)
`ifdef MEM_ARB_PERF_EN
     ,.perf_i_stall(perf_i_stall), .perf_d_stall(perf_d_stall), .perf_acc(perf_acc)
`endif
   );

   initial clk = 0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
      mem[4] <= 32'hDEADBEEF;
      mem[5] <= 32'h0BADF00D;
      mem[6] <= 32'h11223344;
   end

   always_comb begin
      rw = mem[m_addr[7:2]];
      rb = rw[8*m_addr[1:0] +: 8];
      rh = rw[16*m_addr[1] +: 16];
      m_dout = m_rd_ctrl == RD_LB  ? {{24{rb[7]}}, rb} :
               m_rd_ctrl == RD_LBU ? {24'h0, rb} :
               m_rd_ctrl == RD_LH  ? {{16{rh[15]}}, rh} :
               m_rd_ctrl == RD_LHU ? {16'h0, rh} :
               m_rd_ctrl == RD_LW  ? rw : 32'h0;
      wmask = m_wr_ctrl == WR_B ? 32'hFF << (8*m_addr[1:0]) :
              m_wr_ctrl == WR_H ? 32'hFFFF << (16*m_addr[1]) : 32'hFFFF_FFFF;
   end

   always @(posedge clk)
      if (m_wr_ctrl != WR_NONE) mem[m_addr[7:2]] <= (mem[m_addr[7:2]] & ~wmask) | (m_din & wmask);

   // Response monitor: every rvalid must match the oldest outstanding grant, two cycles after it.
   always @(negedge clk) begin
      exp_t e;
      logic [31:0] got;
      if (i_rvalid || d_rvalid) begin
         compared++;
         if (sb.size() == 0) begin
            mismatched++;
            $display("FAIL unexpected_rsp: i_rvalid=%b d_rvalid=%b at cyc %0d with nothing outstanding", i_rvalid, d_rvalid, cyc);
         end else begin
            e = sb.pop_front();
            got = d_rvalid ? d_rdata : i_rdata;
            if ({i_rvalid, d_rvalid} !== {~e.own_d, e.own_d} || got !== e.data || (d_rvalid && d_err !== e.err) || cyc != e.cyc + 2) begin
               mismatched++;
               $display("FAIL rsp: got i_rv=%b d_rv=%b data=%h err=%b cyc=%0d, want own_d=%b data=%h err=%b cyc=%0d",
                        i_rvalid, d_rvalid, got, d_err, cyc, e.own_d, e.data, e.err, e.cyc + 2);
            end
         end
      end
   end

   task automatic d_op(input logic [2:0] rd, input logic [1:0] wr, input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] ed, input logic ee, output logic g);
      @(negedge clk);
      d_req = 1; d_rd_ctrl = rd; d_wr_ctrl = wr; d_addr = a; d_wdata = wd;
      #1;
      g = d_gnt;
      if (g) sb.push_back('{1'b1, ed, ee, cyc});
   endtask

   task automatic d_idle;
      @(negedge clk);
      d_req = 0; d_rd_ctrl = RD_NONE; d_wr_ctrl = WR_NONE; d_wdata = 0;
   endtask

   task automatic test_reset;
      repeat (2) @(negedge clk);
      compared++;
      if ({i_gnt, d_gnt, i_rvalid, d_rvalid, d_err, m_rd_ctrl, m_wr_ctrl} !== 10'b0) begin
         mismatched++;
         $display("FAIL reset_ctl: got %b, want all zero", {i_gnt, d_gnt, i_rvalid, d_rvalid, d_err, m_rd_ctrl, m_wr_ctrl});
      end
      compared++;
      if ({i_rdata, d_rdata, m_addr, m_din} !== 128'b0) begin
         mismatched++;
         $display("FAIL reset_data: got i_rdata=%h d_rdata=%h m_addr=%h m_din=%h, want 0", i_rdata, d_rdata, m_addr, m_din);
      end
      rst = 0;
   endtask

   task automatic test_fetch;
      logic [31:0] addrs [3];
      logic [31:0] exps [3];
      addrs = '{32'h10, 32'h14, 32'h18};
      exps = '{32'hDEADBEEF, 32'h0BADF00D, 32'h11223344};
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         i_req = 1; i_addr = addrs[k];
         #1;
         compared++;
         if (i_gnt !== 1'b1 || d_gnt !== 1'b0) begin
            mismatched++;
            $display("FAIL fetch_gnt%0d: got i_gnt=%b d_gnt=%b, want 1/0", k, i_gnt, d_gnt);
         end
         sb.push_back('{1'b0, exps[k], 1'b0, cyc});
         if (k == 0) begin
            compared++;
            if (m_rd_ctrl !== RD_NONE || m_wr_ctrl !== WR_NONE) begin
               mismatched++;
               $display("FAIL idle_mctl: got rd=%b wr=%b, want 000/00", m_rd_ctrl, m_wr_ctrl);
            end
         end
      end
      @(negedge clk);
      i_req = 0;
      compared++;
      if (m_rd_ctrl !== RD_LW || m_wr_ctrl !== WR_NONE || m_addr !== 32'h18) begin
         mismatched++;
         $display("FAIL fetch_mctl: got rd=%b wr=%b addr=%h, want 101/00/18", m_rd_ctrl, m_wr_ctrl, m_addr);
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_priority;
      logic exp_d;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (c == 0) begin
            i_req = 1; i_addr = 32'h14;
            d_req = 1; d_rd_ctrl = RD_LW; d_wr_ctrl = WR_NONE; d_addr = 32'h10;
         end
         #1;
         exp_d = (c != 4);
         compared++;
         if (d_gnt !== exp_d || i_gnt !== ~exp_d) begin
            mismatched++;
            $display("FAIL prio_c%0d: got d_gnt=%b i_gnt=%b, want %b/%b", c, d_gnt, i_gnt, exp_d, ~exp_d);
         end
         sb.push_back(exp_d ? '{1'b1, 32'hDEADBEEF, 1'b0, cyc} : '{1'b0, 32'h0BADF00D, 1'b0, cyc});
      end
      @(negedge clk);
      i_req = 0; d_req = 0; d_rd_ctrl = RD_NONE;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_store_load;
      logic g0, g1;
      d_op(RD_NONE, WR_W, 32'h20, 32'h12345678, 32'h0, 1'b0, g0);
      d_op(RD_LW, WR_NONE, 32'h20, 32'h0, 32'h12345678, 1'b0, g1);
      d_idle;
      compared++;
      if ({g0, g1} !== 2'b11) begin
         mismatched++;
         $display("FAIL sw_lw_gnt: got %b, want 11", {g0, g1});
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_byte;
      logic g [6];
      d_op(RD_NONE, WR_B, 32'h22, 32'h00AB0000, 32'h0, 1'b0, g[0]);
      d_op(RD_LBU, WR_NONE, 32'h22, 32'h0, 32'h000000AB, 1'b0, g[1]);
      d_op(RD_NONE, WR_B, 32'h23, 32'h80000000, 32'h0, 1'b0, g[2]);
      d_op(RD_LB, WR_NONE, 32'h23, 32'h0, 32'hFFFFFF80, 1'b0, g[3]);
      d_op(RD_LW, WR_W, 32'h20, 32'hCAFEF00D, 32'h80AB5678, 1'b0, g[4]);
      d_op(RD_LHU, WR_NONE, 32'h22, 32'h0, 32'h0000CAFE, 1'b0, g[5]);
      d_idle;
      compared++;
      if ({g[0], g[1], g[2], g[3], g[4], g[5]} !== 6'b111111) begin
         mismatched++;
         $display("FAIL byte_gnt: got %b, want 111111", {g[0], g[1], g[2], g[3], g[4], g[5]});
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_misaligned;
      logic g0, g1, g2;
      d_op(RD_NONE, WR_H, 32'h21, 32'h00FFFF00, 32'h0, 1'b1, g0);
      @(negedge clk);
      d_req = 0; d_wr_ctrl = WR_NONE;
      compared++;
      if (g0 !== 1'b1 || m_wr_ctrl !== WR_NONE || m_rd_ctrl !== RD_NONE || m_din !== 32'h0) begin
         mismatched++;
         $display("FAIL mis_sh: got gnt=%b m_wr=%b m_rd=%b m_din=%h, want 1/00/000/0", g0, m_wr_ctrl, m_rd_ctrl, m_din);
      end
      d_op(RD_LW, WR_NONE, 32'h22, 32'h0, 32'h0, 1'b1, g1);
      d_op(RD_NONE, WR_NONE, 32'h30, 32'h0, 32'h0, 1'b0, g2);
      d_idle;
      compared++;
      if (g1 !== 1'b1 || g2 !== 1'b1 || m_rd_ctrl !== RD_NONE || m_wr_ctrl !== WR_NONE) begin
         mismatched++;
         $display("FAIL nop_acc: got gnt=%b%b m_rd=%b m_wr=%b, want 11/000/00", g1, g2, m_rd_ctrl, m_wr_ctrl);
      end
      repeat (3) @(negedge clk);
      compared++;
      if (mem[8] !== 32'hCAFEF00D) begin
         mismatched++;
         $display("FAIL mis_mem: got mem[8]=%h, want cafef00d", mem[8]);
      end
   endtask

   task automatic test_reset_mid;
      logic g;
      d_op(RD_NONE, WR_W, 32'h24, 32'h55555555, 32'h0, 1'b0, g);
      if (g) void'(sb.pop_back());
      @(negedge clk);
      d_req = 0; d_wr_ctrl = WR_NONE;
      compared++;
      if (g !== 1'b1 || m_wr_ctrl !== WR_W) begin
         mismatched++;
         $display("FAIL rstmid_pre: got gnt=%b m_wr=%b, want 1/11", g, m_wr_ctrl);
      end
      #2 rst = 1;
      #1;
      compared++;
      if (m_wr_ctrl !== WR_NONE || m_addr !== 32'h0 || m_din !== 32'h0) begin
         mismatched++;
         $display("FAIL rstmid_async: got m_wr=%b m_addr=%h m_din=%h, want 00/0/0", m_wr_ctrl, m_addr, m_din);
      end
      @(posedge clk);
      #1;
      compared++;
      if (mem[9] !== 32'h0 || d_rvalid !== 1'b0 || d_rdata !== 32'h0) begin
         mismatched++;
         $display("FAIL rstmid_drop: got mem[9]=%h d_rvalid=%b d_rdata=%h, want 0/0/0", mem[9], d_rvalid, d_rdata);
      end
      @(negedge clk);
      rst = 0;
      repeat (3) @(negedge clk);
   endtask

   initial begin
      rst = 1; i_req = 0; i_addr = 0;
      d_req = 0; d_addr = 0; d_rd_ctrl = RD_NONE; d_wr_ctrl = WR_NONE; d_wdata = 0;
      test_reset;
      test_fetch;
      test_priority;
      test_store_load;
      test_byte;
      test_misaligned;
      test_reset_mid;
      repeat (2) @(negedge clk);
      compared++;
      if (sb.size() != 0) begin
         mismatched++;
         $display("FAIL missing_rsp: %0d responses outstanding, want 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule

// File: doc/mem_arb.md
Name: mem_arb

Overview:
Two-requester arbiter and sequencer for the unified instruction/data memory's single access port. Sits between the fetch stage (I side, read-only word fetch) and the load/store stage (D side), and drives the memory's byte address, rd_ctrl, wr_ctrl and din. Two-stage pipelined: accept, then memory access. Data side has priority, with an age counter that guarantees fetch forward progress.

Parameters:
STARVE_MAX, 4, number of consecutive cycles an I request may lose to D before I gets priority (1..15).
AW, 32, address width.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset, asynchronous, active-high.
i_req  in  1  fetch request; held with i_addr until i_gnt.
i_addr  in  AW  fetch byte address.
i_gnt  out  1  fetch request accepted this cycle.
i_rvalid  out  1  fetch data valid.
i_rdata  out  32  fetched word.
d_req  in  1  data request; held with its payload until d_gnt.
d_addr  in  AW  data byte address.
d_rd_ctrl  in  3  load type: 001 LB, 010 LBU, 011 LH, 100 LHU, 101 LW, 000 none.
d_wr_ctrl  in  2  store type: 01 SB, 10 SH, 11 SW, 00 none.
d_wdata  in  32  store data, already lane-aligned.
d_gnt  out  1  data request accepted this cycle.
d_rvalid  out  1  load data valid, or store acknowledged.
d_rdata  out  32  load result; 0 for stores.
d_err  out  1  misaligned access; qualified by d_rvalid.
m_addr  out  AW  memory byte address.
m_rd_ctrl  out  3  memory read control.
m_wr_ctrl  out  2  memory write control; the memory commits on clk rising edge.
m_din  out  32  memory write data.
m_dout  in  32  memory combinational read data.

Behaviour:
- Reset: all outputs 0, age counter 0, pipeline stages invalid. Asynchronous assertion forces m_wr_ctrl=00 immediately. An in-flight access is dropped with no rvalid.
- Accept (cycle N):
  - At most one gnt per cycle.
  - Winner is D if d_req and age < STARVE_MAX; otherwise I if i_req; otherwise D if d_req.
  - gnt is combinational from req and state. On gnt, the payload and owner tag are latched into stage M at posedge N.
- D request with rd_ctrl=000 and wr_ctrl=000: granted and acknowledged (rvalid, rdata 0), with no memory access.
- Both rd_ctrl and wr_ctrl nonzero: the write takes effect, and rdata is the pre-write value.
- Access (cycle N+1):
  - m_* driven from the stage M register. The write commits at posedge ending N+1.
  - m_dout is registered into rdata at that same edge.
  - For an I access, m_rd_ctrl=101 and m_wr_ctrl=00.
- Response (cycle N+2): owner's rvalid is high for exactly one cycle with rdata. Latency is fixed at 2 cycles; throughput is 1 access per cycle. Back-to-back gnts are allowed.
- Ordering: responses return in grant order. A load granted the cycle after a store to the same word sees the stored data; no hazard logic is needed because the write commits before the later access.
- Misalignment (D only):
  - Conditions: SW/LW with addr[1:0]!=0; SH/LH/LHU with addr[0]=1.
  - Still granted, but stage M drives m_wr_ctrl=00 and m_rd_ctrl=000.
  - Response has d_rvalid=1, d_err=1, d_rdata=0.
- Age counter:
  - Increments, saturating at STARVE_MAX, each cycle i_req=1 and i_gnt=0.
  - Clears on i_gnt or i_req=0.
- When idle, m_rd_ctrl=000, m_wr_ctrl=00, m_addr holds its last value, and m_din=0.
- gnt never asserts without the matching req. Dropping req before gnt is legal, and nothing is issued.

Optional Feature:
MEM_ARB_PERF_EN:
- Defined: adds outputs perf_i_stall[31:0], perf_d_stall[31:0] and perf_acc[31:0].
  - The stall counters count cycles with req=1 and gnt=0.
  - perf_acc counts gnts.
  - All three are wrapping, cleared by rst.
- Undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Package mem_pkg holds:
  - rd_ctrl encodings RD_NONE, RD_LB, RD_LBU, RD_LH, RD_LHU, RD_LW.
  - wr_ctrl encodings WR_NONE, WR_B, WR_H, WR_W.
  - Owner enum OWN_I, OWN_D.
  - Stage M payload struct.
- One sub-module, arb_age_cnt: saturating starvation counter with inputs wait/clear and output the priority flip.

Test Plan:
- Reset, then i_req only with i_addr=0x10 and mem[4]=0xDEADBEEF → i_gnt at N, i_rvalid at N+2 with 0xDEADBEEF; back-to-back fetches give one rvalid per cycle.
- d_req and i_req held together with STARVE_MAX=4 → D granted 4 cycles, I granted on the 5th, then D resumes.
- SW 0x12345678 to 0x20, then next-cycle LW 0x20 → d_rvalid twice consecutively, and the second d_rdata=0x12345678.
- SB 0xAB (lane 2) at 0x22, then LBU 0x22 → d_rdata=0x000000AB; LB of 0x80 gives 0xFFFFFF80.
- SH at 0x21 → d_rvalid=1, d_err=1, m_wr_ctrl stays 00, and memory unchanged.
- rst asserted mid-cycle during an SW in stage M → m_wr_ctrl=00 immediately, no write, no rvalid, outputs 0.
